// File: rtl/hwpe_stream_fault_ctrl_if.sv
// -----------------------------------------------------------------------------
// hwpe_stream_fault_ctrl_if
//
// Purpose:
//   Groups the control inputs and the fault report outputs of
//   hwpe_stream_fault_ctrl into one bundle. The zero-sink side drives fault_i.
//   The HWPE control side drives enable_i, ch_mask_i and clear_i. The report
//   signals flow back out to the register slave.
//
// Signals (named from the controller's point of view):
//   enable_i     detection enabled (level)
//   ch_mask_i    per-channel monitor enable, 1 = monitored
//   fault_i      registered fault flags from the zero sinks
//   clear_i      one-cycle fault acknowledge
//   fault_o      sticky fault flag
//   irq_o        one-cycle pulse on fault entry
//   fault_ch_o   sticky OR of masked faulting channels
//   first_ch_o   lowest channel index of the first fault
//   fault_cnt_o  saturating count of fault cycles
//   state_o      00 DISABLED, 01 SETTLE, 10 ARMED, 11 FAULT
//
// Modports:
//   slave   the fault controller itself
//   master  the surrounding logic (or a testbench) driving it
// -----------------------------------------------------------------------------
interface hwpe_stream_fault_ctrl_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              enable_i;
    logic [N_CH-1:0]   ch_mask_i;
    logic [N_CH-1:0]   fault_i;
    logic              clear_i;
    logic              fault_o;
    logic              irq_o;
    logic [N_CH-1:0]   fault_ch_o;
    logic [IDX_W-1:0]  first_ch_o;
    logic [CNT_W-1:0]  fault_cnt_o;
    logic [1:0]        state_o;

    modport slave (
        input  enable_i,
        input  ch_mask_i,
        input  fault_i,
        input  clear_i,
        output fault_o,
        output irq_o,
        output fault_ch_o,
        output first_ch_o,
        output fault_cnt_o,
        output state_o
    );

    modport master (
        output enable_i,
        output ch_mask_i,
        output fault_i,
        output clear_i,
        input  fault_o,
        input  irq_o,
        input  fault_ch_o,
        input  first_ch_o,
        input  fault_cnt_o,
        input  state_o
    );
endinterface

// File: rtl/hwpe_stream_fault_ctrl.sv
// -----------------------------------------------------------------------------
// hwpe_stream_fault_ctrl
//
// Purpose:
//   Gathers the registered fault flags from up to N_CH zero sinks of an HWPE
//   stream parity network and turns them into one fault report. After enable
//   or after a clear, detection stays disarmed for SETTLE_CYCLES cycles. This
//   gives the zero network time to line up with the normal network. Once
//   armed, the first masked fault does the following:
//     - latches the lowest faulting channel index and the set of faulting
//       channels;
//     - raises a one-cycle interrupt and a sticky fault flag.
//   A saturating counter counts every fault cycle for diagnostics. Only reset
//   clears that counter.
//
// Ports:
//   clk_i   clock, all logic on the rising edge
//   rst_i   synchronous active-high reset
//   ctrl    hwpe_stream_fault_ctrl_if.slave
//           inputs:  enable_i, ch_mask_i, fault_i, clear_i
//           outputs: fault_o, irq_o, fault_ch_o, first_ch_o, fault_cnt_o,
//                    state_o
//
// Parameters:
//   N_CH           number of monitored channels (>= 1)
//   SETTLE_CYCLES  disarmed cycles after enable/clear (0 = arm immediately)
//   CNT_W          width of the saturating fault-cycle counter
//
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module hwpe_stream_fault_ctrl #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    hwpe_stream_fault_ctrl_if.slave ctrl
);

    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned SC_W  = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_SETTLE   = 2'b01,
        ST_ARMED    = 2'b10,
        ST_FAULT    = 2'b11
    } state_e;

    // A zero-length settle window skips SETTLE entirely. The same target is
    // used when leaving DISABLED and when a clear keeps the block enabled.
    localparam state_e ARM_TARGET = (SETTLE_CYCLES == 0) ? ST_ARMED : ST_SETTLE;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_e            state_q,    state_d;
    logic [SC_W-1:0]   settle_q,   settle_d;
    logic              fault_q,    fault_d;
    logic              irq_q,      irq_d;
    logic [N_CH-1:0]   fault_ch_q, fault_ch_d;
    logic [IDX_W-1:0]  first_ch_q, first_ch_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    // -------------------------------------------------------------------------
    // Channel masking and lowest-index priority encoder
    // -------------------------------------------------------------------------
    logic [N_CH-1:0]   masked;
    logic              hit;
    logic [IDX_W-1:0]  lowest_idx;
    logic [CNT_W-1:0]  cnt_inc;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_mask
        assign masked[gi] = ctrl.fault_i[gi] & ctrl.ch_mask_i[gi];
    end

    assign hit = |masked;

    // The loop scans from the top channel down, so the last match, which is
    // the lowest set channel, wins.
    always_comb begin
        lowest_idx = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    end

    // Counter that holds at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        fault_ch_d = fault_ch_q;
        first_ch_d = first_ch_q;
        cnt_d      = cnt_q;
        irq_d      = 1'b0;

        case (state_q)
            ST_DISABLED: begin
                if (ctrl.enable_i) begin
                    state_d  = ARM_TARGET;
                    settle_d = SETTLE_LOAD;
                end
            end

            ST_SETTLE: begin
                // Faults are ignored here. The transition happens on the
                // cycle the counter reaches zero. Because of that, ARMED
                // follows exactly SETTLE_CYCLES cycles of SETTLE.
                if (!ctrl.enable_i) begin
                    state_d  = ST_DISABLED;
                    settle_d = '0;
                end else if (settle_q > SC_W'(1)) begin
                    settle_d = settle_q - SC_W'(1);
                end else begin
                    settle_d = '0;
                    state_d  = ST_ARMED;
                end
            end

            ST_ARMED: begin
                // Disable takes priority over a hit in the same cycle.
                if (!ctrl.enable_i) begin
                    state_d = ST_DISABLED;
                end else if (hit) begin
                    state_d    = ST_FAULT;
                    first_ch_d = lowest_idx;
                    fault_ch_d = masked;
                    cnt_d      = cnt_inc;
                    irq_d      = 1'b1;
                end
            end

            ST_FAULT: begin
                // enable_i alone cannot leave FAULT. Only an acknowledge can.
                // A hit in the same cycle as the clear is dropped.
                if (ctrl.clear_i) begin
                    state_d    = ctrl.enable_i ? ARM_TARGET : ST_DISABLED;
                    settle_d   = ctrl.enable_i ? SETTLE_LOAD : '0;
                    fault_ch_d = '0;
                    first_ch_d = '0;
                end else if (hit) begin
                    fault_ch_d = fault_ch_q | masked;
                    cnt_d      = cnt_inc;
                end
            end

            default: begin
                state_d = ST_DISABLED;
            end
        endcase

        // The sticky flag is registered alongside the state, so it tracks
        // FAULT exactly.
        fault_d = (state_d == ST_FAULT);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_DISABLED;
            settle_q   <= '0;
            fault_q    <= 1'b0;
            irq_q      <= 1'b0;
            fault_ch_q <= '0;
            first_ch_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            fault_q    <= fault_d;
            irq_q      <= irq_d;
            fault_ch_q <= fault_ch_d;
            first_ch_q <= first_ch_d;
            cnt_q      <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ctrl.state_o     = state_q;
    assign ctrl.fault_o     = fault_q;
    assign ctrl.irq_o       = irq_q;
    assign ctrl.fault_ch_o  = fault_ch_q;
    assign ctrl.first_ch_o  = first_ch_q;
    assign ctrl.fault_cnt_o = cnt_q;

endmodule

// File: doc/hwpe_stream_fault_ctrl.md
# hwpe_stream_fault_ctrl

Collects the registered `fault_detected_o` flags from up to `N_CH` zero sinks in an HWPE stream parity network and turns them into one controlled fault report. It arms detection only after a programmable settle window following enable or clear, so the zero network can align with the normal network first. It latches the first and all faulting channels, raises a one-cycle interrupt and a sticky fault flag, and keeps a saturating fault-cycle counter for diagnostics. It sits between the per-stream zero sinks and the HWPE control/register slave.

## Interface
- `N_CH`, 4: number of monitored fault channels (≥1).
- `SETTLE_CYCLES`, 2: cycles faults are ignored after entering SETTLE (0 = arm immediately).
- `CNT_W`, 8: width of the saturating fault counter.

Ports:
- `clk_i`  in  1  clock; one clock domain, all logic on the rising edge.
- `rst_i`  in  1  reset; synchronous and active-high.
- `enable_i`  in  1  level; detection enabled.
- `ch_mask_i`  in  N_CH  per-channel enable; 1 = channel monitored.
- `fault_i`  in  N_CH  fault flags from the zero sinks (already registered there).
- `clear_i`  in  1  one-cycle pulse; acknowledges a fault.
- `fault_o`  out  1  sticky fault flag.
- `irq_o`  out  1  one-cycle pulse on fault entry.
- `fault_ch_o`  out  N_CH  sticky OR of masked faulting channels.
- `first_ch_o`  out  max(1,$clog2(N_CH))  index of the lowest-numbered channel in the first fault.
- `fault_cnt_o`  out  CNT_W  saturating count of fault cycles.
- `state_o`  out  2  current state: 00 DISABLED, 01 SETTLE, 10 ARMED, 11 FAULT.

## Operation
- `masked = fault_i & ch_mask_i`. `hit = |masked`.
- **DISABLED**
  - `enable_i=1` → SETTLE, with settle counter loaded to `SETTLE_CYCLES`.
  - If `SETTLE_CYCLES=0`, go directly to ARMED.
- **SETTLE**
  - Faults are ignored.
  - The counter decrements each cycle. The cycle it reaches 0, the next state is ARMED.
  - `enable_i=0` → DISABLED.
- **ARMED**
  - `enable_i=0` → DISABLED. This has priority over `hit`.
  - `hit` → FAULT, and:
    - `first_ch_o` ← lowest set index of `masked`.
    - `fault_ch_o` ← `masked`.
    - `irq_o` pulses.
    - Counter increments.
- **FAULT**
  - `fault_ch_o |= masked` every cycle.
  - Counter increments on every `hit` cycle.
  - `first_ch_o` is frozen.
  - `enable_i` is ignored.
  - `clear_i` → SETTLE if `enable_i=1`, else DISABLED. Clearing `fault_ch_o` and `first_ch_o` to 0.
  - `clear_i` and `hit` in the same cycle: clear wins, the hit is neither recorded nor counted.
- `clear_i` outside FAULT has no effect.
- `fault_cnt_o` saturates at 2^CNT_W−1. It is cleared only by reset, not by `clear_i`.
- `ch_mask_i` changes take effect on the cycle they are sampled. Bits already latched in `fault_ch_o` stay set.

## Timing
- All outputs are registered. Reset values: `state_o=00`, `fault_o=0`, `irq_o=0`, `fault_ch_o=0`, `first_ch_o=0`, `fault_cnt_o=0`, settle counter 0.
- Reset asserted mid-operation returns everything to reset values on the next edge, regardless of state.
- Fault latency: `hit` sampled in ARMED at edge t. At t+1: `state_o=11`, `fault_o=1`, `irq_o=1`, `first_ch_o`/`fault_ch_o` valid, counter +1. At t+2: `irq_o=0`.
- `fault_o` equals (state == FAULT).
- Settle timing: `enable_i` rises, sampled at edge e. `state_o=01` from e+1. `state_o=10` from e+1+`SETTLE_CYCLES`. The first fault that can be accepted is the one sampled at edge e+1+`SETTLE_CYCLES`.
- Clear: `clear_i` sampled at edge c in FAULT. At c+1: `fault_o=0`, state SETTLE or DISABLED.
- Zero-sink flags lag the stream by one cycle. This block adds one further cycle, so total stream-to-`irq_o` latency is 2 cycles.

## Test plan
- **Reset/idle:** hold `rst_i=1` for 3 cycles with `fault_i=4'hF`, then release with `enable_i=0` → all outputs 0 and `state_o=00` for 10 cycles.
- **Settle masking:** `SETTLE_CYCLES=2`, `enable_i` rises at cycle 0, `fault_i=4'b0100` at cycles 1–2 → no `irq_o`, `state_o=10` at cycle 3. The same fault at cycle 3 → at cycle 4 `irq_o=1`, `first_ch_o=2`, `fault_ch_o=4'b0100`, `fault_cnt_o=1`.
- **Multi-channel and accumulation:** ARMED, `fault_i=4'b1010` for 1 cycle, then `4'b0001` for 2 cycles → `first_ch_o=1`, `fault_ch_o=4'b1011`, `fault_cnt_o=3`, exactly one `irq_o` pulse.
- **Masking:** `ch_mask_i=4'b1110`, `fault_i=4'b0001` for 5 cycles → stays ARMED, count 0. Then `fault_i=4'b0011` → `first_ch_o=1`, `fault_ch_o=4'b0010`.
- **Clear collision and disable:** in FAULT, `clear_i=1` with `fault_i=4'b1000` and `enable_i=1` → next cycle `state_o=01`, `fault_ch_o=0`, count unchanged. Repeat with `enable_i=0` → `state_o=00`.
- **Saturation and mid-op reset:** `CNT_W=2`, hold a masked fault for 6 cycles → `fault_cnt_o` stays at 3. Assert `rst_i` in FAULT → next cycle every output is at its reset value.
